r5p_sim_ctl: RTL and testbench

R5P_SIM_CTL -- requirements
Module: r5p_sim_ctl

---
 rtl/r5p_sim_ctl_pkg.sv | 19 +
 rtl/r5p_fifo_sync.sv | 71 +++++++
 rtl/r5p_sim_ctl.sv | 178 +++++++++++++++++
 tb/tb_r5p_sim_ctl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_sim_ctl_pkg.sv
// rtl/r5p_sim_ctl_pkg.sv - register map, FSM states and exit constants for r5p_sim_ctl
package r5p_sim_ctl_pkg;

   localparam logic [7:0] OFS_DATA_BEGIN = 8'h00;
   localparam logic [7:0] OFS_DATA_END   = 8'h04;
   localparam logic [7:0] OFS_HALT       = 8'h08;
   localparam logic [7:0] OFS_CYCLE      = 8'h0C;
   localparam logic [7:0] OFS_CONSOLE    = 8'h10;
   localparam logic [7:0] OFS_WDOG       = 8'h14;

   localparam logic [31:0] EXIT_TIMEOUT = 32'hDEAD_0001;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/r5p_fifo_sync.sv
// rtl/r5p_fifo_sync.sv - single-clock FIFO, power-of-2 depth, stream-style handshakes
module r5p_fifo_sync #(
   parameter int unsigned DW = 8,
   parameter int unsigned FD = 4,
   localparam int unsigned PW = $clog2(FD),
   localparam int unsigned CW = PW + 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_q [FD];
   logic [DW-1:0] mem_d [FD];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   always_comb begin
      full     = (cnt_q == CW'(FD));
      empty    = (cnt_q == '0);
      count    = cnt_q;
      s_tready = !full;
      m_tvalid = !empty;
      m_tdata  = mem_q[rptr_q];
      push     = s_tvalid && !full;
      pop      = m_tready && !empty;
      mem_d    = mem_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wptr_q] = s_tdata;
         wptr_d        = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/r5p_sim_ctl.sv
// rtl/r5p_sim_ctl.sv - simulation control: signature bounds, halt, cycle counter, console;
// watchdog present only with R5P_SIM_CTL_WATCHDOG_EN defined
module r5p_sim_ctl
   import r5p_sim_ctl_pkg::*;
#(
   parameter int unsigned AW  = 6,
   parameter int unsigned DW  = 32,
   parameter int unsigned FD  = 4,
   parameter int unsigned WDR = 0,
   localparam int unsigned DSW = DW/8
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   input  logic           wen,
   input  logic [AW-1:0]  adr,
   input  logic [DSW-1:0] sel,
   input  logic [DW-1:0]  wdt,
   output logic [DW-1:0]  rdt,
   output logic           ack,
   output logic [DW-1:0]  sig_begin,
   output logic [DW-1:0]  sig_end,
   output logic           halt,
   output logic [DW-1:0]  exit_code,
   output logic           tout,
   output logic           con_vld,
   output logic [7:0]     con_dat,
   input  logic           con_rdy
);

   localparam int unsigned CW = $clog2(FD) + 1;

   state_t        state_q, state_d;
   logic [DW-1:0] begin_q, begin_d, end_q, end_d, exit_q, exit_d, cycle_q, cycle_d;
   logic [DW-1:0] con_status;
   logic [AW-1:0] adr_w;
   logic          wr, rd, con_wr, con_space, con_full, con_empty;
   logic [CW-1:0] con_cnt;
   logic          unused_adr;
`ifdef R5P_SIM_CTL_WATCHDOG_EN
   logic [DW-1:0] wdog_q, wdog_d;
   logic          tout_q, tout_d, wd_wr, wd_expire;
`endif

   function automatic logic hit(input logic [AW-1:0] a, input logic [7:0] ofs);
      return a == AW'(ofs);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] new_v,
                                           input logic [DSW-1:0] be);
      logic [DW-1:0] v;
      v = old_v;
      for (int i = 0; i < DSW; i++) begin
         if (be[i]) v[8*i +: 8] = new_v[8*i +: 8];
      end
      return v;
   endfunction

   assign adr_w      = {adr[AW-1:2], 2'b00};
   assign unused_adr = ^adr[1:0];

   always_comb begin
      wr        = req && wen && (state_q == ST_RUN);
      rd        = req && !wen;
      con_wr    = wr && hit(adr_w, OFS_CONSOLE) && sel[0];
      ack       = !(con_wr && !con_space);
      state_d   = state_q;
      begin_d   = begin_q;
      end_d     = end_q;
      exit_d    = exit_q;
      cycle_d   = cycle_q + DW'(1);

      con_status            = '0;
      con_status[1:0]       = {con_full, con_empty};
      con_status[16 +: CW]  = con_cnt;

      if (wr && hit(adr_w, OFS_DATA_BEGIN)) begin_d = merge(begin_q, wdt, sel);
      if (wr && hit(adr_w, OFS_DATA_END))   end_d   = merge(end_q, wdt, sel);

`ifdef R5P_SIM_CTL_WATCHDOG_EN
      tout_d    = tout_q;
      wdog_d    = wdog_q;
      wd_wr     = wr && hit(adr_w, OFS_WDOG);
      wd_expire = (state_q == ST_RUN) && !wd_wr && (wdog_q == DW'(1));
      if (wd_wr) begin
         wdog_d = merge(wdog_q, wdt, sel);
      end else if ((state_q == ST_RUN) && (wdog_q != '0)) begin
         wdog_d = wdog_q - DW'(1);
      end
`endif

      case (state_q)
         ST_RUN: begin
            // an explicit HALT write outranks a watchdog expiry in the same cycle
            if (wr && hit(adr_w, OFS_HALT)) begin
               state_d = ST_DRAIN;
               exit_d  = wdt;
            end
`ifdef R5P_SIM_CTL_WATCHDOG_EN
            else if (wd_expire) begin
               state_d = ST_DRAIN;
               exit_d  = DW'(EXIT_TIMEOUT);
               tout_d  = 1'b1;
            end
`endif
         end
         ST_DRAIN: begin
            if (con_empty) state_d = ST_HALT;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RUN;
      endcase

      rdt = '0;
      if (rd) begin
         if (hit(adr_w, OFS_DATA_BEGIN))      rdt = begin_q;
         else if (hit(adr_w, OFS_DATA_END))   rdt = end_q;
         else if (hit(adr_w, OFS_CYCLE))      rdt = cycle_q;
         else if (hit(adr_w, OFS_CONSOLE))    rdt = con_status;
`ifdef R5P_SIM_CTL_WATCHDOG_EN
         else if (hit(adr_w, OFS_WDOG))       rdt = wdog_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         begin_q <= '0;
         end_q   <= '0;
         exit_q  <= '0;
         cycle_q <= '0;
`ifdef R5P_SIM_CTL_WATCHDOG_EN
         wdog_q  <= DW'(WDR);
         tout_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         begin_q <= begin_d;
         end_q   <= end_d;
         exit_q  <= exit_d;
         cycle_q <= cycle_d;
`ifdef R5P_SIM_CTL_WATCHDOG_EN
         wdog_q  <= wdog_d;
         tout_q  <= tout_d;
`endif
      end
   end

   r5p_fifo_sync #(
      .DW (8),
      .FD (FD)
   ) u_con_fifo (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (wdt[7:0]),
      .s_tvalid (con_wr),
      .s_tready (con_space),
      .m_tdata  (con_dat),
      .m_tvalid (con_vld),
      .m_tready (con_rdy),
      .count    (con_cnt),
      .full     (con_full),
      .empty    (con_empty)
   );

   assign sig_begin = begin_q;
   assign sig_end   = end_q;
   assign exit_code = exit_q;
   assign halt      = (state_q == ST_HALT);
`ifdef R5P_SIM_CTL_WATCHDOG_EN
   assign tout      = tout_q;
`else
   assign tout      = 1'b0;
`endif

endmodule

// File: tb/tb_r5p_sim_ctl.sv
// tb/tb_r5p_sim_ctl.sv - randomized bench for r5p_sim_ctl against a queue-based reference model
module tb_r5p_sim_ctl;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int FD = 4;
`ifdef R5P_SIM_CTL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic          clk;
   logic          rst, req, wen, con_rdy;
   logic [AW-1:0] adr;
   logic [3:0]    sel;
   logic [DW-1:0] wdt;
   logic [DW-1:0] rdt, sig_begin, sig_end, exit_code;
   logic          ack, halt, tout, con_vld;
   logic [7:0]    con_dat;

   r5p_sim_ctl #(.AW(AW), .DW(DW), .FD(FD), .WDR(0)) dut (
      .clk(clk), .rst(rst), .req(req), .wen(wen), .adr(adr), .sel(sel), .wdt(wdt),
      .rdt(rdt), .ack(ack), .sig_begin(sig_begin), .sig_end(sig_end), .halt(halt),
      .exit_code(exit_code), .tout(tout), .con_vld(con_vld), .con_dat(con_dat),
      .con_rdy(con_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: state 0 = running, 1 = draining, 2 = halted
   logic [31:0] m_begin, m_end, m_exit, m_cycle, m_wd;
   bit          m_tout, mv;
   int          m_state;
   logic [7:0]  m_q[$];
   int          n_checks, n_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rdt(input int a);
      int n;
      n = m_q.size();
      case (a)
         'h00: return m_begin;
         'h04: return m_end;
         'h0C: return m_cycle;
         'h10: return (32'(n) << 16) | (32'(n == FD) << 1) | 32'(n == 0);
         'h14: return WD_EN ? m_wd : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_begin = 0; m_end = 0; m_exit = 0; m_cycle = 0; m_wd = 0;
      m_tout = 0; m_state = 0; m_q.delete(); mv = 1;
   endtask

   task automatic compare();
      int  a;
      bit  exp_ack;
      a = int'({adr[AW-1:2], 2'b00});
      exp_ack = !(m_state == 0 && req && wen && a == 'h10 && sel[0] && m_q.size() == FD);
      chk("ack", 32'(ack), 32'(exp_ack));
      if (req && !wen) chk("rdt", rdt, model_rdt(a));
      chk("halt", 32'(halt), 32'(m_state == 2));
      chk("tout", 32'(tout), 32'(m_tout));
      chk("exit_code", exit_code, m_exit);
      chk("sig_begin", sig_begin, m_begin);
      chk("sig_end", sig_end, m_end);
      chk("con_vld", 32'(con_vld), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("con_dat", 32'(con_dat), 32'(m_q[0]));
   endtask

   task automatic model_next();
      int  a, nstate;
      bit  wr, pop, push, wd_wr, expire;
      if (rst) begin
         model_reset();
      end else if (mv) begin
         a      = int'({adr[AW-1:2], 2'b00});
         wr     = req && wen && m_state == 0;
         pop    = m_q.size() > 0 && con_rdy;
         push   = wr && a == 'h10 && sel[0] && m_q.size() < FD;
         wd_wr  = WD_EN && wr && a == 'h14;
         expire = WD_EN && m_state == 0 && !wd_wr && m_wd == 1;
         nstate = m_state;
         if (m_state == 0 && wr && a == 'h08) begin
            nstate = 1; m_exit = wdt;
         end else if (expire) begin
            nstate = 1; m_exit = 32'hDEAD_0001; m_tout = 1;
         end else if (m_state == 1 && m_q.size() == 0) begin
            nstate = 2;
         end
         if (wr && a == 'h00) m_begin = bmerge(m_begin, wdt, sel);
         if (wr && a == 'h04) m_end = bmerge(m_end, wdt, sel);
         if (wd_wr) m_wd = bmerge(m_wd, wdt, sel);
         else if (m_state == 0 && m_wd != 0) m_wd = m_wd - 1;
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(wdt[7:0]);
         m_cycle = m_cycle + 1;
         m_state = nstate;
      end
   endtask

   task automatic cycle();
      #1;
      if (mv) compare();
      model_next();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic r_i, input logic w_i, input logic [AW-1:0] a_i,
                        input logic [3:0] s_i, input logic [31:0] d_i);
      req = r_i; wen = w_i; adr = a_i; sel = s_i; wdt = d_i;
   endtask

   task automatic do_reset();
      rst = 1; con_rdy = 0;
      drive(0, 0, 0, 0, 0);
      cycle();
      rst = 0;
   endtask

   initial begin
      int k, pops, base, r;
      int addrs[10];
      addrs = '{'h00, 'h04, 'h0C, 'h10, 'h10, 'h10, 'h14, 'h18, 'h3C, 'h08};
      n_checks = 0; n_err = 0; mv = 0;
      rst = 1; con_rdy = 0;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      do_reset();

      // reset state
      drive(1, 0, 6'h0C, 4'h0, 0);
      #1;
      chk("reset_cycle", rdt, 32'd0);
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_con_vld", 32'(con_vld), 32'd0);
      chk("reset_exit", exit_code, 32'd0);
      cycle();

      // byte-lane writes to DATA_BEGIN
      drive(1, 1, 6'h00, 4'b0011, 32'h0000_1000); cycle();
      drive(1, 1, 6'h00, 4'b0001, 32'h0000_ABCD); cycle();
      drive(1, 0, 6'h00, 4'h0, 0);
      #1 chk("lane_merge", rdt, 32'h0000_10CD);
      cycle();

      // console back-pressure with a full FIFO
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 6'h10, 4'h1, 32'h41 + i); cycle();
      end
      drive(1, 1, 6'h10, 4'h1, 32'h45);
      #1 chk("fifth_stalls", 32'(ack), 32'd0);
      con_rdy = 1;
      cycle();
      con_rdy = 0;
      #1 chk("ack_after_pop", 32'(ack), 32'd1);
      cycle();
      drive(1, 0, 6'h10, 4'h0, 0);
      #1 chk("status_count4", rdt, 32'h0004_0002);
      chk("head_after_pop", 32'(con_dat), 32'h42);
      cycle();

      // HALT with pending console bytes drains before halting
      do_reset();
      drive(1, 1, 6'h10, 4'h1, 32'h4F); cycle();
      drive(1, 1, 6'h10, 4'h1, 32'h4B); cycle();
      drive(1, 1, 6'h08, 4'hF, 32'h0); cycle();
      drive(0, 0, 0, 0, 0);
      con_rdy = 1;
      pops = 0;
      for (k = 0; k < 10; k++) begin
         #1;
         if (halt) break;
         if (con_vld && con_rdy) pops++;
         cycle();
      end
      chk("drain_pops", 32'(pops), 32'd2);
      chk("halt_after_drain", 32'(halt), 32'd1);
      chk("halt_exit0", exit_code, 32'd0);
      drive(1, 1, 6'h04, 4'hF, 32'h1234_5678); cycle();
      drive(1, 0, 6'h04, 4'h0, 0);
      #1 chk("write_ignored_halt", rdt, 32'd0);
      cycle();

      // reset while draining
      do_reset();
      drive(1, 1, 6'h10, 4'h1, 32'h31); cycle();
      drive(1, 1, 6'h10, 4'h1, 32'h32); cycle();
      drive(1, 1, 6'h08, 4'hF, 32'h7); cycle();
      drive(0, 0, 0, 0, 0); cycle();
      rst = 1; cycle(); rst = 0;
      drive(1, 0, 6'h0C, 4'h0, 0);
      #1 chk("rst_drain_cycle", rdt, 32'd0);
      chk("rst_drain_vld", 32'(con_vld), 32'd0);
      chk("rst_drain_halt", 32'(halt), 32'd0);
      cycle();
      drive(1, 1, 6'h00, 4'hF, 32'h55); cycle();
      drive(1, 0, 6'h00, 4'h0, 0);
      #1 chk("run_after_rst", rdt, 32'h55);
      cycle();

`ifdef R5P_SIM_CTL_WATCHDOG_EN
      // watchdog expiry
      do_reset();
      drive(1, 1, 6'h14, 4'hF, 32'd10); cycle();
      drive(0, 0, 0, 0, 0);
      k = 0;
      while (k < 30) begin
         #1;
         if (halt) break;
         k++;
         cycle();
      end
      chk("wd_latency", 32'(k), 32'd11);
      chk("wd_tout", 32'(tout), 32'd1);
      chk("wd_exit", exit_code, 32'hDEAD_0001);
      cycle();

      // HALT write in the expiry cycle wins
      do_reset();
      drive(1, 1, 6'h14, 4'hF, 32'd3); cycle();
      drive(0, 0, 0, 0, 0); cycle(); cycle();
      drive(1, 1, 6'h08, 4'hF, 32'h5); cycle();
      drive(0, 0, 0, 0, 0); cycle(); cycle(); cycle();
      #1;
      chk("coincide_exit", exit_code, 32'h5);
      chk("coincide_tout", 32'(tout), 32'd0);
      chk("coincide_halt", 32'(halt), 32'd1);
      cycle();
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         r   = $urandom_range(0, 99);
         rst = (r < 1) || (m_state == 2 && $urandom_range(0, 7) == 0);
         base = addrs[$urandom_range(0, 9)];
         if (base == 'h08 && $urandom_range(0, 30) != 0) base = 'h10;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               AW'(base | $urandom_range(0, 3)), 4'($urandom), $urandom);
         if (base == 'h14) wdt = $urandom_range(0, 25);
         con_rdy = ($urandom_range(0, 2) == 0);
         cycle();
      end
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
